digit_serial_addsub: RTL
========================

# digit_serial_addsub

Digit-serial adder/subtractor producing `a0 ± a1` one `DIGIT_WIDTH`-bit digit per enabled clock, LSB digit first. It generalises the single-bit serial adder to any digit width and adds a subtract mode, a start/done handshake, digit indexing, carry/borrow output and abort. It feeds bit-/digit-serial datapaths of the modular-arithmetic core, e.g. the Montgomery multiplier's accumulate path.

## Interface
- `DATA_WIDTH`, default 1025: operand width in bits.
- `DIGIT_WIDTH`, default 1: bits produced per step; legal range 1..`DATA_WIDTH`.
- `NUM_DIGITS`, derived localparam ceil(`DATA_WIDTH`/`DIGIT_WIDTH`): digits per operation.
- `IDX_WIDTH`, derived localparam max(1, clog2(`NUM_DIGITS`)).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high; overrides `ce`.
- `ce`  in  1  clock enable; when low, all state holds.
- `start`  in  1  launch an operation; accepted only when `ready`=1 and `ce`=1.
- `sub`  in  1  sampled with `start`: 0 = `a0`+`a1`, 1 = `a0`-`a1`.
- `abort`  in  1  with `ce`=1 in RUN: return to IDLE; no `done`.
- `a0`, `a1`  in  `DATA_WIDTH`  operands; sampled only on accepted `start`.
- `ready`  out  1  high in IDLE.
- `digit_valid`  out  1  high in RUN.
- `digit`  out  `DIGIT_WIDTH`  current result digit; 0 when `digit_valid`=0.
- `digit_idx`  out  `IDX_WIDTH`  index of current digit, 0 = LSB.
- `last`  out  1  `digit_valid` and `digit_idx`=`NUM_DIGITS`-1.
- `done`  out  1  high in DONE state.
- `carry_out`  out  1  carry out of bit `DATA_WIDTH`-1; for `sub`, 1 = no borrow (`a0`≥`a1`). Valid while `done`=1; holds until next accepted `start`.

## Operation
- States: IDLE, RUN, DONE. All transitions require `ce`=1, except reset.
- IDLE, accepted `start`:
  - Load `r_a0`=`a0` and `r_a1` = `a1`, or ~`a1` if `sub`=1.
  - Zero-extend both to `NUM_DIGITS`*`DIGIT_WIDTH` bits. Zero-extension happens after the inversion.
  - `r_c`=`sub`, `idx`=0, `carry_out` cleared; go to RUN.
- RUN, combinational:
  - s = low `DIGIT_WIDTH` bits of `r_a0` + low `DIGIT_WIDTH` bits of `r_a1` + `r_c`, computed `DIGIT_WIDTH`+1 bits wide.
  - `digit` = s[`DIGIT_WIDTH`-1:0].
  - On the last digit, bit positions ≥ `DATA_WIDTH` are forced to 0.
- RUN, each `ce` edge:
  - Shift both registers right by `DIGIT_WIDTH`, filling with 0.
  - `r_c` = s[`DIGIT_WIDTH`].
  - `idx`++.
- On the last digit, `carry_out` captures carry into bit `DATA_WIDTH`. This is s[`DATA_WIDTH`-(`NUM_DIGITS`-1)*`DIGIT_WIDTH`], or s[`DIGIT_WIDTH`] when `DIGIT_WIDTH` divides `DATA_WIDTH`. Then go to DONE.
- DONE: one `ce` cycle, then IDLE. `start` is not accepted in DONE.
- `abort` takes priority over the digit step in RUN. A `start` in the same cycle as `abort` is ignored.
- `start` while not IDLE is ignored; operand registers and `sub` are unaffected.
- Reset (any state, mid-operation included):
  - State → IDLE; all registers 0.
  - Outputs: `ready`=1; `digit_valid`, `digit`, `digit_idx`, `last`, `done`, `carry_out` = 0.

## Timing
- `start` accepted at edge T (ce=1): digit k valid in cycle T+1+k, with `ce` continuously high.
- `last` in cycle T+`NUM_DIGITS`; `done` in cycle T+1+`NUM_DIGITS`; `ready` in cycle T+2+`NUM_DIGITS`.
- Back-to-back issue interval: `NUM_DIGITS`+2 cycles.
- `ce` low: the cycle stretches; `digit`, `digit_idx`, `done` hold their values, and no pulse is lost or repeated.
- Digit outputs are combinational from registers (zero-cycle path from `r_a0`/`r_a1`/`r_c`); consumers sample on the edge where `ce`=1.
- Critical path: one `DIGIT_WIDTH`+1 bit adder plus the masking mux.

## Test plan
- `DATA_WIDTH`=8, `DIGIT_WIDTH`=1, add 0xFF+0x01 at T → digits 0×8 at T+1..T+8; `last` at T+8; `done` at T+9 with `carry_out`=1.
- `DATA_WIDTH`=8, `DIGIT_WIDTH`=4, sub 0x05-0x07 → digits 0xE, 0xF; `carry_out`=0. Then sub 0x07-0x05 → digits 0x2, 0x0; `carry_out`=1.
- `DATA_WIDTH`=10, `DIGIT_WIDTH`=4 (`NUM_DIGITS`=3), add 0x3FF+0x001 → digits 0,0,0; last digit upper bits masked; `carry_out`=1. Also sub 0x000-0x001 → digits 0xF, 0xF, 0x3; `carry_out`=0.
- `ce` toggled pseudo-randomly during an 8-bit add of 0xA5+0x3C → digit stream equals 0xE1 LSB-first. Each `digit_idx` value appears for exactly one `ce`=1 edge; `done` is held while `ce`=0.
- `start` pulsed mid-RUN with new operands → ignored; result unchanged. `abort` at digit 3 → IDLE next cycle; no `done`; `ready`=1.
- `rst` asserted at digit 2 → next cycle IDLE with all outputs at reset values. Then a fresh 0x12+0x34 → 0x46; `carry_out`=0.
- Randomised cross-check for {`DIGIT_WIDTH`} ∈ {1, 3, 8, 64} at `DATA_WIDTH`=1025: reassembled digits and `carry_out` equal the reference `a0`±`a1` computed to `DATA_WIDTH`+1 bits.

Source files
------------

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: streams a0 +/- a1 one DIGIT_WIDTH-bit digit
// per enabled clock, LSB digit first, with start/done handshake and abort.
module digit_serial_addsub #(
   parameter  int unsigned DATA_WIDTH  = 1025,
   parameter  int unsigned DIGIT_WIDTH = 1,
   localparam int unsigned NUM_DIGITS  = (DATA_WIDTH + DIGIT_WIDTH - 1) / DIGIT_WIDTH,
   localparam int unsigned IDX_WIDTH   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   input  logic                   start,
   input  logic                   sub,
   input  logic                   abort,
   input  logic [DATA_WIDTH-1:0]  a0,
   input  logic [DATA_WIDTH-1:0]  a1,
   output logic                   ready,
   output logic                   digit_valid,
   output logic [DIGIT_WIDTH-1:0] digit,
   output logic [IDX_WIDTH-1:0]   digit_idx,
   output logic                   last,
   output logic                   done,
   output logic                   carry_out
);

   localparam int unsigned EXT_WIDTH = NUM_DIGITS * DIGIT_WIDTH;
   localparam int unsigned SUM_WIDTH = DIGIT_WIDTH + 1;
   // Number of real operand bits carried by the final digit (1..DIGIT_WIDTH).
   localparam int unsigned LAST_BITS = DATA_WIDTH - (NUM_DIGITS - 1) * DIGIT_WIDTH;
   localparam logic [DIGIT_WIDTH-1:0] LAST_MASK = {DIGIT_WIDTH{1'b1}} >> (DIGIT_WIDTH - LAST_BITS);
   localparam logic [IDX_WIDTH-1:0]   LAST_IDX  = IDX_WIDTH'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e                 state;
   state_e                 state_nxt;
   logic [EXT_WIDTH-1:0]   r_a0;
   logic [EXT_WIDTH-1:0]   r_a1;
   logic                   r_c;
   logic [IDX_WIDTH-1:0]   idx;
   logic [DATA_WIDTH-1:0]  a1_inv;
   logic [SUM_WIDTH-1:0]   sum_c;
   logic                   is_last_c;

   // Digit adder on the low digit of both operand registers plus running carry.
   always_comb begin
      a1_inv    = ~a1;
      sum_c     = {1'b0, r_a0[DIGIT_WIDTH-1:0]} + {1'b0, r_a1[DIGIT_WIDTH-1:0]} + SUM_WIDTH'(r_c);
      is_last_c = (idx == LAST_IDX);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake/digit outputs.
   always_comb begin
      state_nxt   = state;
      ready       = 1'b0;
      digit_valid = 1'b0;
      digit       = '0;
      digit_idx   = '0;
      last        = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (ce && start) state_nxt = RUN;
         end
         RUN: begin
            digit_valid = 1'b1;
            digit_idx   = idx;
            last        = is_last_c;
            // Bits past DATA_WIDTH in the final digit only hold carry spill.
            digit       = is_last_c ? (sum_c[DIGIT_WIDTH-1:0] & LAST_MASK) : sum_c[DIGIT_WIDTH-1:0];
            if (ce) begin
               if (abort)          state_nxt = IDLE;
               else if (is_last_c) state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (ce) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand shift registers, running carry, digit index and final carry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a0      <= '0;
         r_a1      <= '0;
         r_c       <= 1'b0;
         idx       <= '0;
         carry_out <= 1'b0;
      end else if (ce) begin
         case (state)
            IDLE: begin
               if (start) begin
                  // Invert before zero-extension so padding bits stay 0.
                  r_a0      <= EXT_WIDTH'(a0);
                  r_a1      <= sub ? EXT_WIDTH'(a1_inv) : EXT_WIDTH'(a1);
                  r_c       <= sub;
                  idx       <= '0;
                  carry_out <= 1'b0;
               end
            end
            RUN: begin
               if (!abort) begin
                  r_a0 <= r_a0 >> DIGIT_WIDTH;
                  r_a1 <= r_a1 >> DIGIT_WIDTH;
                  r_c  <= sum_c[DIGIT_WIDTH];
                  idx  <= idx + IDX_WIDTH'(1);
                  if (is_last_c) carry_out <= sum_c[LAST_BITS];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
